// File: rtl/dense_relu_seq.sv
// Sequential dense layer: N_OUT parallel MAC lanes stepped over N_IN inputs, valid/ready on both sides.
// Optional macro RELU_EN applies ReLU before saturation; without it the output is signed linear.
module dense_relu_seq #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned N_OUT = 4,
    parameter int unsigned X_W   = 7,
    parameter int unsigned W_W   = 5,
    parameter int unsigned Y_W   = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_IN*X_W-1:0]       x_flat,
    input  logic [N_IN*N_OUT*W_W-1:0] w_flat,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_OUT*Y_W-1:0]      y_flat,
    output logic                      busy
);
    localparam int unsigned ACC_W  = X_W + W_W + $clog2(N_IN) + 1;
    localparam int unsigned PROD_W = X_W + W_W;
    localparam int unsigned EXT_W  = (ACC_W > Y_W) ? ACC_W : Y_W;
    localparam int unsigned IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(N_IN - 1);
    localparam logic signed [Y_W-1:0] Y_MAX    = {1'b0, {(Y_W-1){1'b1}}};
    localparam logic signed [Y_W-1:0] Y_MIN    = {1'b1, {(Y_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, FINAL, DONE} state_t;

    state_t                   state, state_nxt;
    logic                     in_ready_nxt, out_valid_nxt, busy_nxt;
    logic                     accept;
    logic [N_IN*X_W-1:0]      x_reg;
    logic [N_IN*N_OUT*W_W-1:0] w_reg;
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc     [N_OUT];
    logic signed [ACC_W-1:0]  acc_sum [N_OUT];
    logic signed [ACC_W-1:0]  act     [N_OUT];
    logic signed [EXT_W-1:0]  ext     [N_OUT];
    logic [N_OUT*Y_W-1:0]     y_nxt;

    assign accept = in_valid && in_ready;

    // Next-state and registered-output decode
    always_comb begin
        state_nxt     = state;
        in_ready_nxt  = 1'b0;
        out_valid_nxt = 1'b0;
        busy_nxt      = 1'b0;
        case (state)
            IDLE:    if (accept) state_nxt = ACC;
            ACC:     if (idx == LAST_IDX) state_nxt = FINAL;
            FINAL:   state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        in_ready_nxt  = (state_nxt == IDLE);
        busy_nxt      = (state_nxt == ACC) || (state_nxt == FINAL);
        // out_valid lags DONE entry by one cycle: the result register stage
        out_valid_nxt = (state == DONE) && (state_nxt == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
        end
    end

    // MAC lanes, activation and saturation
    always_comb begin
        y_nxt = '0;
        for (int k = 0; k < N_OUT; k++) begin
            acc_sum[k] = acc[k] + ACC_W'(
                PROD_W'($signed(x_reg[idx*X_W +: X_W])) *
                PROD_W'($signed(w_reg[(idx*N_OUT + k)*W_W +: W_W])));
`ifdef RELU_EN
            act[k] = acc[k][ACC_W-1] ? '0 : acc[k];
`else
            act[k] = acc[k];
`endif
            ext[k] = EXT_W'(act[k]);
            if (ext[k] > EXT_W'(Y_MAX))
                y_nxt[k*Y_W +: Y_W] = Y_MAX;
            else if (ext[k] < EXT_W'(Y_MIN))
                y_nxt[k*Y_W +: Y_W] = Y_MIN;
            else
                y_nxt[k*Y_W +: Y_W] = Y_W'(ext[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg  <= '0;
            w_reg  <= '0;
            idx    <= '0;
            y_flat <= '0;
            for (int k = 0; k < N_OUT; k++) acc[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x_reg <= x_flat;
                        w_reg <= w_flat;
                        idx   <= '0;
                        for (int k = 0; k < N_OUT; k++) acc[k] <= '0;
                    end
                end
                ACC: begin
                    for (int k = 0; k < N_OUT; k++) acc[k] <= acc_sum[k];
                    idx <= idx + IDX_W'(1);
                end
                FINAL:   y_flat <= y_nxt;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/dense_relu_seq.md
Name: dense_relu_seq

Overview:
- Parametrised successor to the fixed 4x4 single-cycle dense stage.
- Computes N_OUT neuron outputs y[k] = act(sum over j of x[j]*w[j][k]) for an N_IN-element input vector.
- Uses N_OUT parallel MAC lanes, time-multiplexed over the N_IN inputs, one input per cycle.
- Valid/ready handshakes on both sides, so stages can be chained into a multi-layer pipeline with backpressure.

Parameters:
N_IN, 4, number of input activations per vector (>=1)
N_OUT, 4, number of output neurons (>=1)
X_W, 7, signed input activation width
W_W, 5, signed weight width
Y_W, 14, signed output width; result saturates to this width
ACC_W, X_W+W_W+$clog2(N_IN)+1, internal accumulator width (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  x_flat/w_flat carry a valid vector
in_ready  out  1  block can accept a vector
x_flat  in  N_IN*X_W  x[j] at bits [j*X_W +: X_W], signed
w_flat  in  N_IN*N_OUT*W_W  w[j][k] at bits [(j*N_OUT+k)*W_W +: W_W], signed
out_valid  out  1  y_flat holds a result
out_ready  in  1  downstream accepts the result
y_flat  out  N_OUT*Y_W  y[k] at bits [k*Y_W +: Y_W], signed
busy  out  1  high in ACC state

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0, y_flat=0, accumulators=0, index=0.
- States:
  - IDLE: in_ready=1.
  - ACC: busy=1, in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- IDLE->ACC on in_valid&&in_ready:
  - x_flat and w_flat are captured into internal registers; inputs may change afterwards.
  - Accumulators are cleared and index j=0.
- ACC, each cycle:
  - acc[k] += sext(x[j]) * sext(w[j][k]) for all k, full ACC_W signed precision.
  - j increments by 1.
  - After the cycle with j=N_IN-1, go to FINAL (one cycle, busy=1).
- FINAL:
  - y[k] = sat(act(acc[k])) is registered into y_flat.
  - Next state is DONE.
- Latency: out_valid rises exactly N_IN+2 cycles after the accepting edge (N_IN accumulate cycles + FINAL + register).
- DONE:
  - y_flat and out_valid hold stable until out_valid&&out_ready.
  - On that edge, go to IDLE, out_valid=0; y_flat keeps its last value.
- Throughput: no overlap. The next vector is accepted no earlier than the cycle after the DONE handshake (in_ready=1 in IDLE only).
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Saturation: if acc > 2^(Y_W-1)-1, output 2^(Y_W-1)-1; if acc < -2^(Y_W-1), output -2^(Y_W-1); else truncate exactly.
- Activation: act() is defined under Optional Feature.
- Reset mid-operation: rst asserted in ACC, FINAL or DONE returns immediately to the reset values; the partial result is discarded and out_valid is never pulsed for that vector.
- N_IN=1: ACC lasts one cycle, giving a latency of 3.

Optional Feature:
- Macro RELU_EN.
- Defined: act(a) = (a>0) ? a : 0, applied before saturation, so outputs are never negative.
- Undefined: act(a) = a; signed linear output with symmetric saturation, for final/logit layers.

Test Plan:
- RELU_EN on, defaults; x={1,2,3,4}, all w[j][k]=1 -> y[k]=10 all k, out_valid exactly 6 cycles after accept.
- RELU_EN on; x={10,-5,0,3}, w[j][0]={2,3,4,-1}, w[j][1]={-2,0,0,0} -> y[0]=2, y[1]=0 (ReLU clamps -20). RELU_EN off, same stimulus -> y[1]=-20.
- Y_W=8, RELU_EN off; x all 63, w all 15 -> sum 3780 saturates to 127; x all -64, w all 15 -> -3840 saturates to -128.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> y_flat and out_valid stable, in_ready=0, in_valid pulses ignored. Release -> one handshake, then in_ready=1 the next cycle.
- Reset mid-ACC: assert rst 2 cycles after accept -> out_valid=0, in_ready=1, y_flat=0 immediately; a new vector then produces a correct result.
- Input change after accept: drive new x/w values the cycle after acceptance -> result matches the captured vector; back-to-back vectors give independent results.
